// File: rtl/ast_mux_pkg.sv
// Shared types and helpers for the Avalon-ST packet multiplexer.
package ast_mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    // Modulo wrap for an index known to be below 2*n.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/ast_mux_rr_arbiter.sv
// Round-robin request picker: first requester at or after ptr, wrapping modulo N.
// Purely combinational; no state and no backpressure of its own.
module rr_arbiter
    import ast_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = (N == 1) ? 1 : $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant_idx,
    output logic         any
);

    logic [W-1:0] cand;

    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = W'(rr_wrap(int'(ptr) + i, N));
            if (!any && req[cand]) begin
                any       = 1'b1;
                grant_idx = cand;
            end
        end
    end

endmodule

// File: rtl/ast_mux.sv
// Avalon-ST N:1 packet mux, round-robin per packet; AST_MUX_SRC_TAG_EN replaces channel with source index.
// Latency: first beat 2 cycles (grant + output register), later beats 1 cycle.
// Backpressure: granted input is ready while the output register is empty or draining.
module ast_mux
    import ast_mux_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 8,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
    parameter int TX_DIR        = 4,
    parameter int DIR_SEL_WIDTH = (TX_DIR == 1) ? 1 : $clog2(TX_DIR)
) (
    input  logic                                  clk_i,
    input  logic                                  srst_i,

    input  logic [TX_DIR-1:0][DATA_WIDTH-1:0]     ast_data_i,
    input  logic [TX_DIR-1:0]                     ast_startofpacket_i,
    input  logic [TX_DIR-1:0]                     ast_endofpacket_i,
    input  logic [TX_DIR-1:0]                     ast_valid_i,
    input  logic [TX_DIR-1:0][EMPTY_WIDTH-1:0]    ast_empty_i,
    input  logic [TX_DIR-1:0][CHANNEL_WIDTH-1:0]  ast_channel_i,
    output logic [TX_DIR-1:0]                     ast_ready_o,

    output logic [DATA_WIDTH-1:0]                 ast_data_o,
    output logic                                  ast_startofpacket_o,
    output logic                                  ast_endofpacket_o,
    output logic                                  ast_valid_o,
    output logic [EMPTY_WIDTH-1:0]                ast_empty_o,
    output logic [CHANNEL_WIDTH-1:0]              ast_channel_o,
    input  logic                                  ast_ready_i,
    output logic [DIR_SEL_WIDTH-1:0]              ast_dir_o
);

`ifdef AST_MUX_SRC_TAG_EN
    if (DIR_SEL_WIDTH > CHANNEL_WIDTH) begin : g_tag_width_check
        $error("ast_mux: source tag does not fit in the channel field");
    end
`endif

    state_t                   state;
    state_t                   state_nxt;
    logic [DIR_SEL_WIDTH-1:0] grant;
    logic [DIR_SEL_WIDTH-1:0] ptr;
    logic [DIR_SEL_WIDTH-1:0] ptr_nxt;
    logic [DIR_SEL_WIDTH-1:0] arb_idx;
    logic                     arb_any;
    logic                     grant_rdy;
    logic                     accept;

    rr_arbiter #(
        .N (TX_DIR),
        .W (DIR_SEL_WIDTH)
    ) u_arb (
        .req       (ast_valid_i),
        .ptr       (ptr),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // The owner may push whenever the output slot is free or being drained this cycle.
    assign grant_rdy = (state == PKT) && (!ast_valid_o || ast_ready_i);
    assign accept    = grant_rdy && ast_valid_i[grant];
    assign ptr_nxt   = DIR_SEL_WIDTH'(rr_wrap(int'(grant) + 1, TX_DIR));

    always_comb begin
        state_nxt   = state;
        ast_ready_o = '0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    state_nxt = PKT;
                end
            end
            PKT: begin
                ast_ready_o[grant] = grant_rdy;
                if (accept && ast_endofpacket_i[grant]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state               <= IDLE;
            grant               <= '0;
            ptr                 <= '0;
            ast_data_o          <= '0;
            ast_startofpacket_o <= 1'b0;
            ast_endofpacket_o   <= 1'b0;
            ast_valid_o         <= 1'b0;
            ast_empty_o         <= '0;
            ast_channel_o       <= '0;
            ast_dir_o           <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && arb_any) begin
                grant <= arb_idx;
            end
            if (accept) begin
                ast_data_o          <= ast_data_i[grant];
                ast_startofpacket_o <= ast_startofpacket_i[grant];
                ast_endofpacket_o   <= ast_endofpacket_i[grant];
                ast_valid_o         <= 1'b1;
                ast_empty_o         <= ast_empty_i[grant];
`ifdef AST_MUX_SRC_TAG_EN
                ast_channel_o       <= CHANNEL_WIDTH'(grant);
`else
                ast_channel_o       <= ast_channel_i[grant];
`endif
                ast_dir_o           <= grant;
                if (ast_endofpacket_i[grant]) begin
                    ptr <= ptr_nxt;
                end
            end else if (ast_ready_i) begin
                ast_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ast_mux.sv
// Directed bench for ast_mux: per-input source queues, output beat recorder, per-scenario checks.
module tb_ast_mux;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int EW = 3;
    localparam int N  = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 srst;
    logic [N-1:0][DW-1:0] data_d;
    logic [N-1:0]         sop_d, eop_d, vld_d;
    logic [N-1:0][EW-1:0] empty_d;
    logic [N-1:0][CW-1:0] ch_d;
    logic [N-1:0]         rdy_o;
    logic [DW-1:0]        data_o;
    logic                 sop_o, eop_o, vld_o;
    logic [EW-1:0]        empty_o;
    logic [CW-1:0]        ch_o;
    logic                 rdy;
    logic [SW-1:0]        dir_o;

    ast_mux #(
        .DATA_WIDTH    (DW),
        .CHANNEL_WIDTH (CW),
        .EMPTY_WIDTH   (EW),
        .TX_DIR        (N),
        .DIR_SEL_WIDTH (SW)
    ) dut (
        .clk_i               (clk),
        .srst_i              (srst),
        .ast_data_i          (data_d),
        .ast_startofpacket_i (sop_d),
        .ast_endofpacket_i   (eop_d),
        .ast_valid_i         (vld_d),
        .ast_empty_i         (empty_d),
        .ast_channel_i       (ch_d),
        .ast_ready_o         (rdy_o),
        .ast_data_o          (data_o),
        .ast_startofpacket_o (sop_o),
        .ast_endofpacket_o   (eop_o),
        .ast_valid_o         (vld_o),
        .ast_empty_o         (empty_o),
        .ast_channel_o       (ch_o),
        .ast_ready_i         (rdy),
        .ast_dir_o           (dir_o)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic [CW-1:0] ch;
        logic [SW-1:0] dir;
    } beat_t;

    beat_t      src_q[N][$];
    beat_t      exp_q[$];
    beat_t      rec_q[$];
    logic [N-1:0] acc;
    int vectors     = 0;
    int miscompares = 0;

    function automatic beat_t mk_beat(input int src, input int tag, input int b, input int n,
                                      input logic [CW-1:0] ch);
        beat_t t;
        t.data  = (64'(src) << 24) | (64'(tag) << 16) | 64'(b);
        t.sop   = (b == 0);
        t.eop   = (b == n - 1);
        t.empty = t.eop ? EW'(src + 1) : '0;
        t.ch    = ch;
        t.dir   = SW'(src);
        return t;
    endfunction

    task automatic push_pkt(input int src, input int tag, input int n, input logic [CW-1:0] ch);
        for (int b = 0; b < n; b++) src_q[src].push_back(mk_beat(src, tag, b, n, ch));
    endtask

    task automatic expect_pkt(input int src, input int tag, input int n, input logic [CW-1:0] ch);
        beat_t t;
        for (int b = 0; b < n; b++) begin
            t = mk_beat(src, tag, b, n, ch);
`ifdef AST_MUX_SRC_TAG_EN
            t.ch = CW'(src);
`endif
            exp_q.push_back(t);
        end
    endtask

    // Source model: present queue heads, pop what the DUT accepted on the previous edge.
    initial begin
        beat_t h;
        vld_d = '0; sop_d = '0; eop_d = '0; data_d = '0; empty_d = '0; ch_d = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (srst) src_q[i].delete();
                else if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    h = src_q[i][0];
                    vld_d[i] = 1'b1; data_d[i] = h.data; sop_d[i] = h.sop;
                    eop_d[i] = h.eop; empty_d[i] = h.empty; ch_d[i] = h.ch;
                end else begin
                    vld_d[i] = 1'b0; data_d[i] = '0; sop_d[i] = 1'b0;
                    eop_d[i] = 1'b0; empty_d[i] = '0; ch_d[i] = '0;
                end
            end
        end
    end

    initial begin
        beat_t r;
        acc = '0;
        forever begin
            @(negedge clk);
            acc = vld_d & rdy_o;
            if (vld_o && rdy && !srst) begin
                r.data = data_o; r.sop = sop_o; r.eop = eop_o;
                r.empty = empty_o; r.ch = ch_o; r.dir = dir_o;
                rec_q.push_back(r);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 srst = 1'b1;
        @(posedge clk); #1 srst = 1'b0;
        rec_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (rec_q.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (rec_q.size() < n) begin
            vectors++; miscompares++;
            $display("FAIL wait_beats: got %0d beats, required %0d", rec_q.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vectors++; if (vld_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b, required 0", vld_o); end
        vectors++; if ({sop_o, eop_o} !== 2'b00) begin miscompares++; $display("FAIL rst_sop_eop: got %b, required 00", {sop_o, eop_o}); end
        vectors++; if (data_o !== '0) begin miscompares++; $display("FAIL rst_data: got %h, required 0", data_o); end
        vectors++; if ({empty_o, ch_o, dir_o} !== '0) begin miscompares++; $display("FAIL rst_side: got %h, required 0", {empty_o, ch_o, dir_o}); end
        vectors++; if (rdy_o !== '0) begin miscompares++; $display("FAIL rst_ready: got %b, required 0000", rdy_o); end
    endtask

    task automatic test_single_pkt();
        beat_t got;
        @(negedge clk);
        push_pkt(2, 1, 3, 8'h12);
        expect_pkt(2, 1, 3, 8'h12);
        @(negedge clk);
        vectors++; if (vld_o !== 1'b0) begin miscompares++; $display("FAIL t1_lat_c0: got valid %b, required 0", vld_o); end
        @(negedge clk);
        vectors++; if (vld_o !== 1'b0) begin miscompares++; $display("FAIL t1_lat_c1: got valid %b, required 0", vld_o); end
        @(negedge clk);
        vectors++; if ({vld_o, sop_o, dir_o} !== {1'b1, 1'b1, 2'd2}) begin
            miscompares++; $display("FAIL t1_lat_c2: got vld/sop/dir %b, required 1110", {vld_o, sop_o, dir_o});
        end
        wait_beats(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = '0; if (i < rec_q.size()) got = rec_q[i];
            vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL t1_beat%0d: got %h, required %h", i, got, exp_q[i]); end
        end
        rec_q.delete(); exp_q.delete();
    endtask

    task automatic test_rr_order();
        beat_t got;
        do_reset();
        @(negedge clk);
        for (int s = 0; s < N; s++) push_pkt(s, 2, 2, CW'(8'h10 + s));
        for (int s = 0; s < N; s++) expect_pkt(s, 2, 2, CW'(8'h10 + s));
        wait_beats(exp_q.size());
        @(negedge clk);
        push_pkt(3, 3, 2, 8'h13);
        push_pkt(1, 3, 2, 8'h11);
        expect_pkt(1, 3, 2, 8'h11);
        expect_pkt(3, 3, 2, 8'h13);
        wait_beats(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = '0; if (i < rec_q.size()) got = rec_q[i];
            vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL t2_beat%0d: got %h, required %h", i, got, exp_q[i]); end
        end
        rec_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        beat_t got;
        logic [DW-1:0] held;
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        held = '0;
        do_reset();
        rdy = 1'b1;
        @(negedge clk);
        push_pkt(2, 4, 4, 8'h12);
        expect_pkt(2, 4, 4, 8'h12);
        k = 0;
        while (!vld_o && k < 50) begin @(negedge clk); k++; end
        vectors++; if (vld_o !== 1'b1) begin miscompares++; $display("FAIL t3_start: got valid %b, required 1", vld_o); end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1 rdy = pat[3-c];
            @(negedge clk);
            if (c == 1) held = data_o;
            if (!rdy) begin
                vectors++; if ({vld_o, rdy_o[2]} !== 2'b10) begin
                    miscompares++; $display("FAIL t3_stall%0d: got valid/ready %b, required 10", c, {vld_o, rdy_o[2]});
                end
                vectors++; if (data_o !== held) begin
                    miscompares++; $display("FAIL t3_hold%0d: got %h, required %h", c, data_o, held);
                end
            end
        end
        @(posedge clk); #1 rdy = 1'b1;
        wait_beats(exp_q.size());
        repeat (5) @(negedge clk);
        vectors++; if (rec_q.size() != exp_q.size()) begin
            miscompares++; $display("FAIL t3_count: got %0d beats, required %0d", rec_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = '0; if (i < rec_q.size()) got = rec_q[i];
            vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL t3_beat%0d: got %h, required %h", i, got, exp_q[i]); end
        end
        rec_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        beat_t got;
        do_reset();
        @(negedge clk);
        for (int t = 0; t < 3; t++) begin
            push_pkt(1, t, 1, 8'h11);
            push_pkt(0, t, 1, 8'h10);
        end
        for (int t = 0; t < 3; t++) begin
            expect_pkt(0, t, 1, 8'h10);
            expect_pkt(1, t, 1, 8'h11);
        end
        wait_beats(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = '0; if (i < rec_q.size()) got = rec_q[i];
            vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL t4_beat%0d: got %h, required %h", i, got, exp_q[i]); end
        end
        rec_q.delete(); exp_q.delete();
    endtask

    task automatic test_mid_reset();
        beat_t got;
        do_reset();
        @(negedge clk);
        push_pkt(1, 5, 1, 8'h11);
        wait_beats(1);
        @(negedge clk);
        push_pkt(2, 6, 4, 8'h12);
        wait_beats(3);
        do_reset();
        @(negedge clk);
        vectors++; if ({vld_o, sop_o, eop_o, rdy_o} !== '0) begin
            miscompares++; $display("FAIL t5_rst_ctl: got %b, required 0", {vld_o, sop_o, eop_o, rdy_o});
        end
        vectors++; if ({data_o, empty_o, ch_o, dir_o} !== '0) begin
            miscompares++; $display("FAIL t5_rst_dat: got %h, required 0", {data_o, empty_o, ch_o, dir_o});
        end
        push_pkt(2, 7, 2, 8'h12);
        push_pkt(0, 8, 2, 8'h10);
        expect_pkt(0, 8, 2, 8'h10);
        expect_pkt(2, 7, 2, 8'h12);
        wait_beats(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = '0; if (i < rec_q.size()) got = rec_q[i];
            vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL t5_beat%0d: got %h, required %h", i, got, exp_q[i]); end
        end
        rec_q.delete(); exp_q.delete();
    endtask

    task automatic test_channel();
        logic [CW-1:0] want;
        beat_t got;
`ifdef AST_MUX_SRC_TAG_EN
        want = 8'h03;
`else
        want = 8'hAB;
`endif
        do_reset();
        @(negedge clk);
        push_pkt(3, 9, 2, 8'hAB);
        expect_pkt(3, 9, 2, 8'hAB);
        wait_beats(exp_q.size());
        got = '0; if (rec_q.size() > 0) got = rec_q[0];
        vectors++; if (got.ch !== want) begin miscompares++; $display("FAIL t6_channel: got %h, required %h", got.ch, want); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = '0; if (i < rec_q.size()) got = rec_q[i];
            vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL t6_beat%0d: got %h, required %h", i, got, exp_q[i]); end
        end
        rec_q.delete(); exp_q.delete();
    endtask

    initial begin
        srst = 1'b1;
        rdy  = 1'b1;
        test_reset();
        test_single_pkt();
        test_rr_order();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_channel();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
